// File: rtl/dpi_feeder_pkg.sv
// Shared types and sizing for the DPI stream feeder and its stream table.
package dpi_feeder_pkg;

    localparam int unsigned STREAM_ID_W = 6;
    localparam int unsigned NUM_STREAMS = 64;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StLoad,
        StGap,
        StStream,
        StDrain,
        StEop
    } feeder_state_e;

endpackage

// File: rtl/dpi_stream_feeder_if.sv
// Byte-wide packet stream with a flow key carried on the SOP beat.
interface dpi_stream_feeder_if #(
    parameter int unsigned FLOW_W = 32
);
    logic              pkt_vld;
    logic              pkt_rdy;
    logic              pkt_sop;
    logic              pkt_eop;
    logic [7:0]        pkt_data;
    logic [FLOW_W-1:0] flow_key;

    modport master (
        output pkt_vld, pkt_sop, pkt_eop, pkt_data, flow_key,
        input  pkt_rdy
    );

    modport slave (
        input  pkt_vld, pkt_sop, pkt_eop, pkt_data, flow_key,
        output pkt_rdy
    );
endinterface

// File: rtl/dpi_stream_table.sv
// Flow-key to stream-ID table: parallel compare, lowest-index hit, lowest free slot,
// round-robin eviction through alloc_ptr when full.
module dpi_stream_table
    import dpi_feeder_pkg::*;
#(
    parameter int unsigned FLOW_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLOW_W-1:0]      key,
    input  logic                   lookup,
    input  logic                   flush,
    output logic [STREAM_ID_W-1:0] idx,
    output logic                   hit,
    output logic                   full
);

    logic [FLOW_W-1:0]      keys [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid;
    logic [NUM_STREAMS-1:0] match;
    logic [STREAM_ID_W-1:0] alloc_ptr;
    logic [STREAM_ID_W-1:0] hit_idx;
    logic [STREAM_ID_W-1:0] free_idx;

    // Scan downwards so the lowest matching / free index is the one left standing.
    always_comb begin
        match    = '0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            match[i] = valid[i] && (keys[i] == key);
        end
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (match[i]) hit_idx = STREAM_ID_W'(i);
            if (!valid[i]) free_idx = STREAM_ID_W'(i);
        end
    end

    assign hit  = |match;
    assign full = &valid;
    assign idx  = hit ? hit_idx : (full ? alloc_ptr : free_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= '0;
            alloc_ptr <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (lookup && !hit) begin
            valid[idx] <= 1'b1;
            if (full) alloc_ptr <= alloc_ptr + 1'b1;
        end
    end

    // Key storage is only meaningful under valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (lookup && !hit) keys[idx] <= key;
    end

endmodule

// File: rtl/dpi_stream_feeder.sv
// Feeds a shared matcher bus: maps flow keys to stream IDs and sequences
// load_state, chars and eop. Optional counters under DPI_FEEDER_STATS_EN.
module dpi_stream_feeder
    import dpi_feeder_pkg::*;
#(
    parameter int unsigned FLOW_W    = 32,
    parameter int unsigned NUM_RULES = 16,
    parameter int unsigned LOAD_GAP  = 2,
    parameter int unsigned EOP_GAP   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    dpi_stream_feeder_if.slave     pkt,
    input  logic [NUM_RULES-1:0]   rule_en_cfg,
    input  logic                   tbl_flush,
    output logic                   load_state,
    output logic [STREAM_ID_W-1:0] stream_id,
    output logic                   new_stream_id,
    output logic [7:0]             char_in,
    output logic                   char_in_vld,
    output logic                   eop,
    output logic [NUM_RULES-1:0]   enable,
    output logic                   sop_err
`ifdef DPI_FEEDER_STATS_EN
    ,
    output logic [31:0]            stat_pkts,
    output logic [31:0]            stat_new,
    output logic [31:0]            stat_evict
`endif
);

    feeder_state_e          state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic                   flush_pend_q;
    logic [FLOW_W-1:0]      key_q;
    logic [NUM_RULES-1:0]   en_cfg_q;
    logic [STREAM_ID_W-1:0] tbl_idx;
    logic                   tbl_hit;
    logic                   tbl_full;
    logic                   tbl_flush_apply;

    // A flush arriving mid-packet waits for the packet to end so stream_id stays valid.
    assign tbl_flush_apply = (state_q == StIdle && tbl_flush) ||
                             (state_q == StEop && (flush_pend_q || tbl_flush));

    dpi_stream_table #(
        .FLOW_W (FLOW_W)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .key    (key_q),
        .lookup (state_q == StLookup),
        .flush  (tbl_flush_apply),
        .idx    (tbl_idx),
        .hit    (tbl_hit),
        .full   (tbl_full)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        pkt.pkt_rdy = 1'b0;
        load_state  = 1'b0;
        char_in     = '0;
        char_in_vld = 1'b0;
        eop         = 1'b0;
        sop_err     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // SOP beat is held upstream and becomes the first char in StStream.
                pkt.pkt_rdy = !pkt.pkt_sop && !rst;
                if (pkt.pkt_vld && pkt.pkt_sop) state_d = StLookup;
            end
            StLookup: state_d = StLoad;
            StLoad: begin
                load_state = 1'b1;
                cnt_d      = '0;
                first_d    = 1'b1;
                state_d    = (LOAD_GAP == 0) ? StStream : StGap;
            end
            StGap: begin
                if (cnt_q + 32'd1 >= LOAD_GAP) state_d = StStream;
                else                           cnt_d   = cnt_q + 32'd1;
            end
            StStream: begin
                pkt.pkt_rdy = 1'b1;
                char_in     = pkt.pkt_data;
                char_in_vld = pkt.pkt_vld;
                sop_err     = pkt.pkt_vld && pkt.pkt_sop && !first_q;
                if (pkt.pkt_vld) begin
                    first_d = 1'b0;
                    if (pkt.pkt_eop) begin
                        cnt_d   = '0;
                        state_d = (EOP_GAP == 0) ? StEop : StDrain;
                    end
                end
            end
            StDrain: begin
                if (cnt_q + 32'd1 >= EOP_GAP) state_d = StEop;
                else                          cnt_d   = cnt_q + 32'd1;
            end
            StEop: begin
                eop     = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            first_q       <= 1'b0;
            flush_pend_q  <= 1'b0;
            key_q         <= '0;
            en_cfg_q      <= '0;
            stream_id     <= '0;
            new_stream_id <= 1'b0;
            enable        <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            if (state_q == StIdle && pkt.pkt_vld && pkt.pkt_sop) begin
                key_q    <= pkt.flow_key;
                en_cfg_q <= rule_en_cfg;
            end
            if (state_q == StLookup) begin
                stream_id     <= tbl_idx;
                new_stream_id <= !tbl_hit;
                enable        <= en_cfg_q;
            end
            if (state_q == StEop)                         flush_pend_q <= 1'b0;
            else if (tbl_flush && state_q != StIdle)      flush_pend_q <= 1'b1;
        end
    end

`ifdef DPI_FEEDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pkts  <= '0;
            stat_new   <= '0;
            stat_evict <= '0;
        end else begin
            if (eop && stat_pkts != '1) stat_pkts <= stat_pkts + 32'd1;
            if (load_state && new_stream_id && stat_new != '1) stat_new <= stat_new + 32'd1;
            if (state_q == StLookup && !tbl_hit && tbl_full && stat_evict != '1) begin
                stat_evict <= stat_evict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dpi_stream_feeder.sv
// Self-checking bench for dpi_stream_feeder: a flow-table model predicts stream IDs,
// a compare process checks the matcher bus every cycle, directed tests pin key cases.
module tb_dpi_stream_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rule_en_cfg;
    logic        tbl_flush;
    logic        load_state;
    logic [5:0]  stream_id;
    logic        new_stream_id;
    logic [7:0]  char_in;
    logic        char_in_vld;
    logic        eop;
    logic [15:0] enable;
    logic        sop_err;
`ifdef DPI_FEEDER_STATS_EN
    logic [31:0] stat_pkts, stat_new, stat_evict;
`endif

    dpi_stream_feeder_if #(.FLOW_W(32)) pkt_if ();

    dpi_stream_feeder #(
        .FLOW_W    (32),
        .NUM_RULES (16),
        .LOAD_GAP  (2),
        .EOP_GAP   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pkt           (pkt_if.slave),
        .rule_en_cfg   (rule_en_cfg),
        .tbl_flush     (tbl_flush),
        .load_state    (load_state),
        .stream_id     (stream_id),
        .new_stream_id (new_stream_id),
        .char_in       (char_in),
        .char_in_vld   (char_in_vld),
        .eop           (eop),
        .enable        (enable),
        .sop_err       (sop_err)
`ifdef DPI_FEEDER_STATS_EN
        ,
        .stat_pkts     (stat_pkts),
        .stat_new      (stat_new),
        .stat_evict    (stat_evict)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  sid;
        logic        is_new;
        logic [15:0] en;
    } exp_t;

    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic [7:0]  char_q[$];
    logic [7:0]  tx_q[$];
    exp_t        cur;
    int          cyc = 0;
    int          load_cyc = 0;
    int          last_char_cyc = 0;
    bit          first_pend = 0;
    int          eop_cnt = 0;
    int          sop_err_cnt = 0;
    logic [5:0]  last_sid;
    logic        last_new;

    // Flow table model: lowest hit, else lowest free, else round-robin victim.
    logic [31:0] m_key[64];
    bit          m_vld[64];
    int          m_ptr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear(input bit reset_ptr);
        for (int i = 0; i < 64; i++) m_vld[i] = 0;
        if (reset_ptr) m_ptr = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] k, output int sid, output bit is_new);
        sid = -1;
        for (int i = 0; i < 64; i++) if (sid < 0 && m_vld[i] && m_key[i] == k) sid = i;
        if (sid >= 0) begin
            is_new = 0;
            return;
        end
        is_new = 1;
        for (int i = 0; i < 64; i++) if (sid < 0 && !m_vld[i]) sid = i;
        if (sid < 0) begin
            sid   = m_ptr;
            m_ptr = (m_ptr + 1) % 64;
        end
        m_key[sid] = k;
        m_vld[sid] = 1;
    endfunction

    // Compare process: matcher bus against model expectations, every cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            if (load_state) begin
                check("load_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("load_sid", 64'(stream_id), 64'(cur.sid));
                    check("load_new", 64'(new_stream_id), 64'(cur.is_new));
                    check("load_en", 64'(enable), 64'(cur.en));
                    last_sid   = stream_id;
                    last_new   = new_stream_id;
                    load_cyc   = cyc;
                    first_pend = 1;
                end
            end
            if (char_in_vld) begin
                check("char_expected", 64'(char_q.size() != 0), 64'd1);
                if (char_q.size() != 0) check("char", 64'(char_in), 64'(char_q.pop_front()));
                if (first_pend) begin
                    check("load_to_char", 64'(cyc - load_cyc), 64'd3);
                    first_pend = 0;
                end
                check("char_sid", 64'(stream_id), 64'(cur.sid));
                check("char_en", 64'(enable), 64'(cur.en));
                last_char_cyc = cyc;
            end
            if (eop) begin
                check("char_to_eop", 64'(cyc - last_char_cyc), 64'd4);
                check("eop_sid", 64'(stream_id), 64'(cur.sid));
                check("eop_en", 64'(enable), 64'(cur.en));
                eop_cnt++;
            end
            if (sop_err) sop_err_cnt++;
        end
    end

    task automatic wait_eop();
        int k  = 0;
        int c0 = eop_cnt;
        while (eop_cnt == c0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("eop_seen", 64'(eop_cnt - c0), 64'd1);
        #1;
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic send_pkt(input logic [31:0] key, input logic [15:0] en, input bit toggle,
                            input int sop_at, input bit wait_end);
        int   sid;
        bit   nw;
        exp_t e;
        int   n;
        int   k;
        n = tx_q.size();
        model_lookup(key, sid, nw);
        e.sid    = 6'(sid);
        e.is_new = nw;
        e.en     = en;
        exp_q.push_back(e);
        foreach (tx_q[i]) char_q.push_back(tx_q[i]);
        for (int i = 0; i < n; i++) begin
            pkt_if.pkt_vld  = 1'b1;
            pkt_if.pkt_sop  = (i == 0) || (i == sop_at);
            pkt_if.pkt_eop  = (i == n - 1);
            pkt_if.pkt_data = tx_q[i];
            pkt_if.flow_key = key;
            rule_en_cfg     = en;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!pkt_if.pkt_rdy && k < 200);
            if (k >= 200) check("beat_accepted", 64'(pkt_if.pkt_rdy), 64'd1);
            @(posedge clk);
            #1;
            pkt_if.pkt_vld = 1'b0;
            pkt_if.pkt_sop = 1'b0;
            pkt_if.pkt_eop = 1'b0;
            if (toggle && i < n - 1) begin
                @(posedge clk);
                #1;
            end
        end
        if (wait_end) wait_eop();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_load_state"}, 64'(load_state), 64'd0);
        check({tag, "_stream_id"}, 64'(stream_id), 64'd0);
        check({tag, "_new_stream_id"}, 64'(new_stream_id), 64'd0);
        check({tag, "_char_in"}, 64'(char_in), 64'd0);
        check({tag, "_char_in_vld"}, 64'(char_in_vld), 64'd0);
        check({tag, "_eop"}, 64'(eop), 64'd0);
        check({tag, "_enable"}, 64'(enable), 64'd0);
        check({tag, "_sop_err"}, 64'(sop_err), 64'd0);
        check({tag, "_pkt_rdy"}, 64'(pkt_if.pkt_rdy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst             = 1'b1;
        tbl_flush       = 1'b0;
        rule_en_cfg     = '0;
        pkt_if.pkt_vld  = 1'b0;
        pkt_if.pkt_sop  = 1'b0;
        pkt_if.pkt_eop  = 1'b0;
        pkt_if.pkt_data = '0;
        pkt_if.flow_key = '0;
        model_clear(1);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Non-SOP beats in IDLE are accepted and dropped.
        pkt_if.pkt_vld  = 1'b1;
        pkt_if.pkt_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_drop_rdy", 64'(pkt_if.pkt_rdy), 64'd1);
            check("idle_drop_no_char", 64'(char_in_vld), 64'd0);
            @(posedge clk);
            #1;
        end
        pkt_if.pkt_vld = 1'b0;

        tx_q = {8'h4E, 8'h42, 8'h54, 8'h53};
        send_pkt(32'hA5A5_0001, 16'hBEEF, 0, -1, 1);
        check("first_sid", 64'(last_sid), 64'd0);
        check("first_new", 64'(last_new), 64'd1);

        tx_q = {8'h01, 8'h02};
        send_pkt(32'hA5A5_0001, 16'h1234, 0, -1, 1);
        check("repeat_sid", 64'(last_sid), 64'd0);
        check("repeat_new", 64'(last_new), 64'd0);

        tx_q = {8'h61};
        send_pkt(32'hB0B0_0002, 16'h8001, 0, -1, 1);
        check("second_key_sid", 64'(last_sid), 64'd1);
        check("second_key_new", 64'(last_new), 64'd1);

        tx_q = {8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        send_pkt(32'hB0B0_0002, 16'h5A5A, 1, -1, 1);
        check("toggle_sid", 64'(last_sid), 64'd1);

        c0 = sop_err_cnt;
        tx_q = {8'h41, 8'h42, 8'h43, 8'h44};
        send_pkt(32'hA5A5_0001, 16'h0F0F, 0, 2, 1);
        check("sop_err_once", 64'(sop_err_cnt - c0), 64'd1);

        // Flush during the packet: eop still carries stream 2 (checked by compare process).
        tx_q = {8'h11, 8'h22, 8'h33, 8'h44};
        fork
            send_pkt(32'hC0C0_0003, 16'h00FF, 0, -1, 1);
            begin
                repeat (4) @(posedge clk);
                #1 tbl_flush = 1'b1;
                @(posedge clk);
                #1 tbl_flush = 1'b0;
            end
        join
        check("flush_pkt_sid", 64'(last_sid), 64'd2);
        model_clear(0);
        tx_q = {8'h55};
        send_pkt(32'hA5A5_0001, 16'h0001, 0, -1, 1);
        check("post_flush_sid", 64'(last_sid), 64'd0);
        check("post_flush_new", 64'(last_new), 64'd1);

        for (int i = 1; i < 64; i++) begin
            tx_q = {8'(i)};
            send_pkt(32'h1000_0000 + i, 16'(i), 0, -1, 1);
        end
        check("fill_last_sid", 64'(last_sid), 64'd63);
        tx_q = {8'hE5};
        send_pkt(32'h2000_0065, 16'hAAAA, 0, -1, 1);
        check("evict65_sid", 64'(last_sid), 64'd0);
        check("evict65_new", 64'(last_new), 64'd1);
        tx_q = {8'hE6};
        send_pkt(32'h2000_0066, 16'h5555, 0, -1, 1);
        check("evict66_sid", 64'(last_sid), 64'd1);
        tx_q = {8'hE7};
        send_pkt(32'hA5A5_0001, 16'h0002, 0, -1, 1);
        check("evicted_key_sid", 64'(last_sid), 64'd2);
        check("evicted_key_new", 64'(last_new), 64'd1);

        // Reset while draining: outputs drop at once, no eop follows.
        tx_q = {8'hAB, 8'hCD};
        send_pkt(32'h3000_0001, 16'hC3C3, 0, -1, 0);
        c0  = eop_cnt;
        rst = 1'b1;
        #1;
        check_all_zero("drain_rst");
        model_clear(1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_eop_after_rst", 64'(eop_cnt - c0), 64'd0);

        tx_q = {8'h99, 8'h98};
        send_pkt(32'hA5A5_0001, 16'h7777, 0, -1, 1);
        check("after_rst_sid", 64'(last_sid), 64'd0);
        check("after_rst_new", 64'(last_new), 64'd1);

        check("sop_err_total", 64'(sop_err_cnt), 64'd1);
        check("chars_consumed", 64'(char_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
